// File: rtl/comb_test_pkg.sv
// Shared types and defaults for the combinational-unit self-test sequencer.
package comb_test_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned DefNIn = 3;

  // 3-input majority: output is 1 when at least two inputs are 1.
  localparam logic [7:0] DefMajority = 8'b1110_1000;

endpackage

// File: rtl/comb_test_seq_if.sv
// Signals between the self-test sequencer (master) and its controller/unit side (slave).
interface comb_test_seq_if
  import comb_test_pkg::*;
#(
  parameter int unsigned N_IN = DefNIn
) ();

  logic            start;
  logic            f_in;
  logic [N_IN-1:0] x_out;
  logic            busy;
  logic            chk_valid;
  logic            chk_ok;
  logic            done;
  logic            pass;
  logic [N_IN:0]   fail_cnt;
  logic [N_IN-1:0] first_fail;

  modport master (
    input  start, f_in,
    output x_out, busy, chk_valid, chk_ok, done, pass, fail_cnt, first_fail
  );

  modport slave (
    output start, f_in,
    input  x_out, busy, chk_valid, chk_ok, done, pass, fail_cnt, first_fail
  );

endinterface

// File: rtl/comb_test_seq.sv
// Walks every input vector through a combinational unit, holds it SETTLE cycles,
// then compares the unit's output against a truth table and tallies failures.
module comb_test_seq
  import comb_test_pkg::*;
#(
  parameter int unsigned        N_IN     = DefNIn,
  parameter int unsigned        SETTLE   = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = DefMajority
) (
  input logic             clk,
  input logic             rst,
  comb_test_seq_if.master bus
);

  localparam int unsigned     CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LastIdx = {N_IN{1'b1}};

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;
  logic            fail_seen_q, fail_seen_d;
  logic            pass_q, pass_d;
  logic            mismatch;

  assign mismatch = (bus.f_in != EXPECTED[idx_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StApply;
      StApply: if (cnt_q == CntLast) state_d = StCheck;
      StCheck: state_d = (idx_q == LastIdx) ? StDone : StApply;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.chk_valid = 1'b0;
    bus.chk_ok    = 1'b0;
    bus.done      = 1'b0;
    unique case (state_q)
      StApply: bus.busy = 1'b1;
      StCheck: begin
        bus.busy      = 1'b1;
        bus.chk_valid = 1'b1;
        bus.chk_ok    = ~mismatch;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Counters and result registers.
  always_comb begin
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    pass_d       = pass_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          idx_d        = '0;
          cnt_d        = '0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
          pass_d       = 1'b0;
        end
      end
      StApply: cnt_d = cnt_q + 1'b1;
      StCheck: begin
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (!fail_seen_q) begin
            first_fail_d = idx_q;
            fail_seen_d  = 1'b1;
          end
        end
        if (idx_q == LastIdx) begin
          // Loaded on entry to DONE so pass is already valid alongside the done pulse.
          pass_d = (fail_cnt_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      pass_q       <= pass_d;
    end
  end

  // The index only moves on entry to APPLY, so it doubles as the held vector.
  assign bus.x_out      = idx_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.first_fail = first_fail_q;
  assign bus.pass       = pass_q;

endmodule

// File: tb/tb_comb_test_seq.sv
// Bench for comb_test_seq: three sequencers (majority, single-bit fault, stuck-at-0)
// checked every cycle against a timing-formula model plus literal expectations.
module tb_comb_test_seq;

  typedef struct packed {
    logic [2:0] x;
    logic       busy;
    logic       cv;
    logic       ok;
    logic       done;
    logic       pass;
    logic [3:0] fc;
    logic [2:0] ff;
  } out_t;

  logic clk;
  logic rst;
  logic start;

  int   n_vec;
  int   n_bad;
  int   t_rel;
  int   done_t[3];
  int   ndone[3];
  int   nvalid[3];
  int   nok[3];

  int         s_tab[3]     = '{2, 2, 1};
  logic [7:0] tbl_tab[3]   = '{8'b1110_1000, 8'b1100_1000, 8'b1110_1000};
  bit         stuck_tab[3] = '{1'b0, 1'b0, 1'b1};

  int   run_t[3];
  out_t held[3];
  bit   armed;
  out_t dut_o[3];

  comb_test_seq_if #(.N_IN(3)) bus0 ();
  comb_test_seq_if #(.N_IN(3)) bus1 ();
  comb_test_seq_if #(.N_IN(3)) bus2 ();

  comb_test_seq #(.N_IN(3), .SETTLE(2), .EXPECTED(8'b1110_1000)) u_maj (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  comb_test_seq #(.N_IN(3), .SETTLE(2), .EXPECTED(8'b1100_1000)) u_flt (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  comb_test_seq #(.N_IN(3), .SETTLE(1), .EXPECTED(8'b1110_1000)) u_stk (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Units under test: majority gate for the first two, output stuck at 0 for the third.
  assign bus0.f_in  = (bus0.x_out[0] & bus0.x_out[1]) | (bus0.x_out[0] & bus0.x_out[2]) |
                      (bus0.x_out[1] & bus0.x_out[2]);
  assign bus1.f_in  = (bus1.x_out[0] & bus1.x_out[1]) | (bus1.x_out[0] & bus1.x_out[2]) |
                      (bus1.x_out[1] & bus1.x_out[2]);
  assign bus2.f_in  = 1'b0;
  assign bus0.start = start;
  assign bus1.start = start;
  assign bus2.start = start;

  assign dut_o[0] = {bus0.x_out, bus0.busy, bus0.chk_valid, bus0.chk_ok, bus0.done, bus0.pass,
                     bus0.fail_cnt, bus0.first_fail};
  assign dut_o[1] = {bus1.x_out, bus1.busy, bus1.chk_valid, bus1.chk_ok, bus1.done, bus1.pass,
                     bus1.fail_cnt, bus1.first_fail};
  assign dut_o[2] = {bus2.x_out, bus2.busy, bus2.chk_valid, bus2.chk_ok, bus2.done, bus2.pass,
                     bus2.fail_cnt, bus2.first_fail};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit maj3(int v);
    return (((v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1)) >= 2);
  endfunction

  // Outputs t cycles after an accepted start, from the published timing rules.
  function automatic out_t model_run(int t, int s, logic [7:0] tbl, bit stuck);
    out_t o;
    int   p;
    int   fc;
    int   ff;
    int   x;
    bit   f;
    o  = '0;
    p  = s + 1;
    fc = 0;
    ff = -1;
    for (int k = 0; k < 8; k++) begin
      f = stuck ? 1'b0 : maj3(k);
      if ((k + 1) * p < t && f != tbl[k]) begin
        fc++;
        if (ff < 0) ff = k;
      end
    end
    x      = (t <= 8 * p) ? (t - 1) / p : 7;
    o.x    = 3'(x);
    o.busy = (t >= 1 && t <= 8 * p);
    o.cv   = o.busy && (t % p == 0);
    f      = stuck ? 1'b0 : maj3(x);
    o.ok   = o.cv && (f == tbl[x]);
    o.done = (t == 8 * p + 1);
    o.pass = o.done && (fc == 0);
    o.fc   = 4'(fc);
    o.ff   = (ff < 0) ? 3'd0 : 3'(ff);
    return o;
  endfunction

  function automatic out_t to_idle(out_t o);
    out_t r;
    r      = o;
    r.done = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        run_t[i] <= 0;
        held[i]  <= '0;
      end else if (run_t[i] == 0) begin
        if (start) run_t[i] <= 1;
      end else if (run_t[i] == 8 * (s_tab[i] + 1) + 1) begin
        run_t[i] <= 0;
        held[i]  <= to_idle(model_run(run_t[i], s_tab[i], tbl_tab[i], stuck_tab[i]));
      end else begin
        run_t[i] <= run_t[i] + 1;
      end
    end
    if (rst) armed <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One cycle: compare all instances at the falling edge, then step past the rising edge.
  task automatic tick();
    out_t e;
    @(negedge clk);
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        e = (run_t[i] == 0) ? held[i] :
            model_run(run_t[i], s_tab[i], tbl_tab[i], stuck_tab[i]);
        n_vec++;
        if (dut_o[i] !== e) begin
          n_bad++;
          $display("FAIL cycle inst%0d t=%0d actual x=%0d b=%0d v=%0d ok=%0d d=%0d p=%0d fc=%0d ff=%0d required x=%0d b=%0d v=%0d ok=%0d d=%0d p=%0d fc=%0d ff=%0d",
                   i, t_rel, dut_o[i].x, dut_o[i].busy, dut_o[i].cv, dut_o[i].ok,
                   dut_o[i].done, dut_o[i].pass, dut_o[i].fc, dut_o[i].ff,
                   e.x, e.busy, e.cv, e.ok, e.done, e.pass, e.fc, e.ff);
        end
        if (dut_o[i].cv === 1'b1) nvalid[i]++;
        if (dut_o[i].cv === 1'b1 && dut_o[i].ok === 1'b1) nok[i]++;
        if (dut_o[i].done === 1'b1) begin
          ndone[i]++;
          if (done_t[i] < 0) done_t[i] = t_rel;
        end
      end
    end
    @(posedge clk);
    #1;
    t_rel++;
  endtask

  task automatic begin_run();
    start = 1'b1;
    t_rel = 0;
    for (int i = 0; i < 3; i++) begin
      done_t[i] = -1;
      ndone[i]  = 0;
      nvalid[i] = 0;
      nok[i]    = 0;
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    t_rel = 0;
    armed = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_t[i] = -1;
      ndone[i]  = 0;
      nvalid[i] = 0;
      nok[i]    = 0;
    end
    tick();
    tick();
    chk("reset_outputs_maj", int'(dut_o[0]), 0);
    chk("reset_outputs_stk", int'(dut_o[2]), 0);
    rst = 1'b0;
    tick();
    tick();

    // Full runs on all three sequencers in parallel.
    begin_run();
    tick();
    start = 1'b0;
    repeat (29) tick();
    chk("maj_done_t", done_t[0], 25);
    chk("maj_strobes", nvalid[0], 8);
    chk("maj_ok_strobes", nok[0], 8);
    chk("maj_fail_cnt", int'(bus0.fail_cnt), 0);
    chk("maj_pass", int'(bus0.pass), 1);
    chk("flt_done_t", done_t[1], 25);
    chk("flt_ok_strobes", nok[1], 7);
    chk("flt_fail_cnt", int'(bus1.fail_cnt), 1);
    chk("flt_first_fail", int'(bus1.first_fail), 5);
    chk("flt_pass", int'(bus1.pass), 0);
    chk("stk_done_t", done_t[2], 17);
    chk("stk_fail_cnt", int'(bus2.fail_cnt), 4);
    chk("stk_first_fail", int'(bus2.first_fail), 3);
    chk("stk_pass", int'(bus2.pass), 0);

    // Reset during APPLY of vector 3, then a clean run.
    begin_run();
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("mid_x_before_rst", int'(bus0.x_out), 3);
    chk("mid_busy_before_rst", int'(bus0.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_outputs_after_rst", int'(dut_o[0]), 0);
    repeat (2) tick();
    begin_run();
    tick();
    start = 1'b0;
    repeat (29) tick();
    chk("rerun_done_t", done_t[0], 25);
    chk("rerun_pass", int'(bus0.pass), 1);

    // Start pulsed while vector 4 is applied must be ignored.
    begin_run();
    tick();
    start = 1'b0;
    repeat (12) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("busy_start_done_t", done_t[0], 25);
    chk("busy_start_ndone", ndone[0], 1);
    chk("busy_start_fail_cnt", int'(bus0.fail_cnt), 0);
    chk("busy_start_stk_ndone", ndone[2], 1);

    // Held start: second run's vector 0 appears at t=27.
    begin_run();
    repeat (27) tick();
    chk("held_done_t", done_t[0], 25);
    chk("held_x_t27", int'(bus0.x_out), 0);
    chk("held_busy_t27", int'(bus0.busy), 1);
    start = 1'b0;
    repeat (60) tick();
    chk("held_final_pass", int'(bus0.pass), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
